// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding/hazard tracker.
// Entry fields are sized for the widest supported config; instances narrow them by cast.
package fwd_pkg;

    localparam int unsigned FWD_RD_W        = 8;
    localparam int unsigned FWD_AVAIL_W     = 8;
    localparam int unsigned FWD_SEL_REGFILE = 0;

    typedef struct packed {
        logic                   valid;
        logic [FWD_RD_W-1:0]    rd;
        logic [FWD_AVAIL_W-1:0] avail;
    } fwd_entry_t;

    function automatic logic [FWD_AVAIL_W-1:0] avail_of(input logic        is_load,
                                                        input int unsigned alu_avail,
                                                        input int unsigned load_avail);
        return is_load ? FWD_AVAIL_W'(load_avail) : FWD_AVAIL_W'(alu_avail);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority matcher over the in-flight producer entries.
// The youngest matching entry (lowest index) decides the select and readiness.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  fwd_entry_t [NUM_STAGES-1:0] entries,
    input  logic [REG_AW-1:0]           rs,
    input  logic                        uses_rs,
    output logic                        hit,
    output logic [SEL_W-1:0]            sel,
    output logic                        not_ready
);

    always_comb begin
        hit       = 1'b0;
        sel       = SEL_W'(FWD_SEL_REGFILE);
        not_ready = 1'b0;
        // Scan oldest to youngest so the youngest match overwrites.
        for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
            if (entries[k].valid && uses_rs && (rs != '0) &&
                (entries[k].rd == FWD_RD_W'(rs))) begin
                hit       = 1'b1;
                sel       = SEL_W'(k + 1);
                not_ready = (k + 1) < int'(entries[k].avail);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_tracker.sv
// Forwarding and load-use hazard unit driven by an internal scoreboard of
// in-flight destination registers that shifts down the pipeline each advance.
module fwd_hazard_tracker
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned ALU_AVAIL  = 1,
    parameter int unsigned LOAD_AVAIL = 2,
    parameter int unsigned SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              id_valid,
    input  logic [REG_AW-1:0]                 id_rs1,
    input  logic [REG_AW-1:0]                 id_rs2,
    input  logic                              id_uses_rs1,
    input  logic                              id_uses_rs2,
    input  logic [REG_AW-1:0]                 id_rd,
    input  logic                              id_writes_rd,
    input  logic                              id_is_load,
    input  logic                              pipe_freeze,
    input  logic                              flush,
    output logic                              hazard_stall,
    output logic [SEL_W-1:0]                  ex_fwd_sel_rs1,
    output logic [SEL_W-1:0]                  ex_fwd_sel_rs2,
    output logic [$clog2(NUM_STAGES+1)-1:0]   inflight_cnt
);

    localparam int unsigned CNT_W = $clog2(NUM_STAGES + 1);

    fwd_entry_t [NUM_STAGES-1:0] entries_q, entries_d;
    fwd_entry_t                  new_entry;
    logic [SEL_W-1:0]            sel1_q, sel1_d, sel2_q, sel2_d;
    logic [SEL_W-1:0]            sel1_m, sel2_m;
    logic                        hit1, hit2, nr1, nr2;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    fwd_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_match_rs1 (
        .entries   (entries_q),
        .rs        (id_rs1),
        .uses_rs   (id_uses_rs1),
        .hit       (hit1),
        .sel       (sel1_m),
        .not_ready (nr1)
    );

    fwd_match #(
        .NUM_STAGES (NUM_STAGES),
        .REG_AW     (REG_AW),
        .SEL_W      (SEL_W)
    ) u_match_rs2 (
        .entries   (entries_q),
        .rs        (id_rs2),
        .uses_rs   (id_uses_rs2),
        .hit       (hit2),
        .sel       (sel2_m),
        .not_ready (nr2)
    );

    // Deliberately independent of freeze/flush so upstream sees a stable stall.
    assign hazard_stall = id_valid && (nr1 || nr2);

    always_comb begin
        new_entry       = '0;
        new_entry.valid = id_valid && id_writes_rd && (id_rd != '0);
        new_entry.rd    = FWD_RD_W'(id_rd);
        new_entry.avail = avail_of(id_is_load, ALU_AVAIL, LOAD_AVAIL);
    end

    always_comb begin
        entries_d = entries_q;
        sel1_d    = sel1_q;
        sel2_d    = sel2_q;
        if (!pipe_freeze) begin
            // A flush kills the instruction leaving EX, so slot 1 receives a bubble.
            for (int i = int'(NUM_STAGES) - 1; i >= 1; i--) begin
                entries_d[i] = (flush && (i == 1)) ? '0 : entries_q[i-1];
            end
            entries_d[0] = '0;
            sel1_d       = SEL_W'(FWD_SEL_REGFILE);
            sel2_d       = SEL_W'(FWD_SEL_REGFILE);
            if (!flush && !hazard_stall) begin
                entries_d[0] = new_entry;
                sel1_d       = hit1 ? sel1_m : SEL_W'(FWD_SEL_REGFILE);
                sel2_d       = hit2 ? sel2_m : SEL_W'(FWD_SEL_REGFILE);
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            cnt_d = cnt_d + CNT_W'(entries_d[i].valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '0;
            sel1_q    <= '0;
            sel2_q    <= '0;
            cnt_q     <= '0;
        end else begin
            entries_q <= entries_d;
            sel1_q    <= sel1_d;
            sel2_q    <= sel2_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_fwd_sel_rs1 = sel1_q;
    assign ex_fwd_sel_rs2 = sel2_q;
    assign inflight_cnt   = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker: a queue-of-producers model checked every
// cycle, plus hand-computed expectations at the interesting points.
module tb_fwd_hazard_tracker;

    localparam int unsigned NS    = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned ALU_A = 1;
    localparam int unsigned LD_A  = 2;
    localparam int unsigned SW    = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_uses_rs1, id_uses_rs2, id_writes_rd, id_is_load;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          pipe_freeze, flush;
    logic          hazard_stall;
    logic [SW-1:0] ex_fwd_sel_rs1, ex_fwd_sel_rs2;
    logic [SW-1:0] inflight_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_tracker #(
        .NUM_STAGES (NS),
        .REG_AW     (AW),
        .ALU_AVAIL  (ALU_A),
        .LOAD_AVAIL (LD_A)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_rd          (id_rd),
        .id_writes_rd   (id_writes_rd),
        .id_is_load     (id_is_load),
        .pipe_freeze    (pipe_freeze),
        .flush          (flush),
        .hazard_stall   (hazard_stall),
        .ex_fwd_sel_rs1 (ex_fwd_sel_rs1),
        .ex_fwd_sel_rs2 (ex_fwd_sel_rs2),
        .inflight_cnt   (inflight_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: every producer that writes a real register, with the number of
    // advances since it entered EX. Age+1 is the stage register holding it.
    typedef struct {
        logic [AW-1:0] rd;
        bit            ld;
        int            age;
    } prod_t;

    prod_t prods[$];
    int    exp_sel1 = 0;
    int    exp_sel2 = 0;

    function automatic int model_sel(input logic [AW-1:0] rs, input logic use_rs,
                                     output bit not_ready);
        int best   = 0;
        int need   = 0;
        not_ready  = 0;
        if (use_rs && rs != 0) begin
            foreach (prods[i]) begin
                if (prods[i].rd == rs && (best == 0 || prods[i].age + 1 < best)) begin
                    best = prods[i].age + 1;
                    need = prods[i].ld ? LD_A : ALU_A;
                end
            end
        end
        not_ready = (best != 0) && (best < need);
        return best;
    endfunction

    function automatic void model_advance(input bit kill_ex);
        prod_t nq[$];
        foreach (prods[i]) begin
            if (!(kill_ex && prods[i].age == 0) && prods[i].age + 1 < int'(NS))
                nq.push_back('{prods[i].rd, prods[i].ld, prods[i].age + 1});
        end
        prods = nq;
    endfunction

    always @(negedge rst_n) begin
        prods.delete();
        exp_sel1 = 0;
        exp_sel2 = 0;
    end

    always @(negedge clk) begin
        int s1, s2;
        bit nr1, nr2, st;
        if (!rst_n) begin
            prods.delete();
            exp_sel1 = 0;
            exp_sel2 = 0;
        end else begin
            s1 = model_sel(id_rs1, id_uses_rs1, nr1);
            s2 = model_sel(id_rs2, id_uses_rs2, nr2);
            st = id_valid && (nr1 || nr2);
            chk("model_stall", hazard_stall, st);
            chk("model_sel_rs1", ex_fwd_sel_rs1, exp_sel1);
            chk("model_sel_rs2", ex_fwd_sel_rs2, exp_sel2);
            chk("model_inflight", inflight_cnt, prods.size());
            if (!pipe_freeze) begin
                exp_sel1 = 0;
                exp_sel2 = 0;
                if (flush) begin
                    model_advance(1);
                end else if (st) begin
                    model_advance(0);
                end else begin
                    model_advance(0);
                    if (id_valid && id_writes_rd && id_rd != 0)
                        prods.push_back('{id_rd, id_is_load, 0});
                    exp_sel1 = s1;
                    exp_sel2 = s2;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] r1, input logic u1,
                          input logic [AW-1:0] r2, input logic u2,
                          input logic [AW-1:0] rd, input logic w, input logic ld);
        id_valid     = v;
        id_rs1       = r1;
        id_uses_rs1  = u1;
        id_rs2       = r2;
        id_uses_rs2  = u2;
        id_rd        = rd;
        id_writes_rd = w;
        id_is_load   = ld;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        pipe_freeze = 1'b0;
        flush       = 1'b0;
        idle();
        #1;
        chk("reset_sel_rs1", ex_fwd_sel_rs1, 0);
        chk("reset_inflight", inflight_cnt, 0);
        chk("reset_stall", hazard_stall, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Two valid entries, then reset pulsed between edges
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        tick();
        set_id(1, 3, 1, 0, 0, 4, 1, 0);
        tick();
        chk("pre_reset_inflight", inflight_cnt, 2);
        chk("pre_reset_sel_rs1", ex_fwd_sel_rs1, 1);
        set_id(1, 4, 1, 3, 1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_inflight", inflight_cnt, 0);
        chk("async_reset_sel_rs1", ex_fwd_sel_rs1, 0);
        chk("async_reset_stall", hazard_stall, 0);
        #1;
        rst_n = 1'b1;
        idle();
        tick();

        // add x5 ; add x6,x5,x1
        set_id(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        #1;
        chk("alu_use_stall", hazard_stall, 0);
        tick();
        chk("alu_use_sel_rs1", ex_fwd_sel_rs1, 1);
        chk("alu_use_sel_rs2", ex_fwd_sel_rs2, 0);

        // lw x6 ; sub x7,x6,x6
        set_id(1, 0, 0, 0, 0, 6, 1, 1);
        tick();
        set_id(1, 6, 1, 6, 1, 7, 1, 0);
        #1;
        chk("load_use_stall", hazard_stall, 1);
        tick();
        chk("load_use_bubble_sel_rs1", ex_fwd_sel_rs1, 0);
        chk("load_use_bubble_sel_rs2", ex_fwd_sel_rs2, 0);
        chk("load_use_stall_released", hazard_stall, 0);
        tick();
        chk("load_use_sel_rs1", ex_fwd_sel_rs1, 2);
        chk("load_use_sel_rs2", ex_fwd_sel_rs2, 2);

        // add x7 ; add x7 ; use x7 -> youngest wins
        set_id(1, 0, 0, 0, 0, 7, 1, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 7, 1, 0);
        tick();
        set_id(1, 7, 1, 0, 0, 8, 1, 0);
        #1;
        chk("youngest_stall", hazard_stall, 0);
        tick();
        chk("youngest_sel_rs1", ex_fwd_sel_rs1, 1);

        // add x0 ; use x0 -> never forwarded
        set_id(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_id(1, 0, 1, 0, 1, 9, 1, 0);
        #1;
        chk("x0_stall", hazard_stall, 0);
        tick();
        chk("x0_sel_rs1", ex_fwd_sel_rs1, 0);
        chk("x0_sel_rs2", ex_fwd_sel_rs2, 0);

        // lw x6 with a freeze over the load-use stall
        idle();
        tick();
        tick();
        chk("drain_inflight", inflight_cnt, 0);
        set_id(1, 0, 0, 0, 0, 6, 1, 1);
        tick();
        chk("frz_load_inflight", inflight_cnt, 1);
        set_id(1, 6, 1, 6, 1, 7, 1, 0);
        #1;
        chk("frz_stall_before", hazard_stall, 1);
        pipe_freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_stall_held", hazard_stall, 1);
            chk("frz_inflight_held", inflight_cnt, 1);
        end
        pipe_freeze = 1'b0;
        tick();
        chk("frz_after_bubble_sel", ex_fwd_sel_rs1, 0);
        chk("frz_after_stall", hazard_stall, 0);
        tick();
        chk("frz_final_sel_rs1", ex_fwd_sel_rs1, 2);
        chk("frz_final_sel_rs2", ex_fwd_sel_rs2, 2);
        chk("frz_final_inflight", inflight_cnt, 1);

        // add x9 in EX, consumer in ID, flush kills both
        idle();
        tick();
        tick();
        set_id(1, 0, 0, 0, 0, 9, 1, 0);
        tick();
        chk("flush_pre_inflight", inflight_cnt, 1);
        set_id(1, 9, 1, 0, 0, 10, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_inflight", inflight_cnt, 0);
        chk("flush_sel_rs1", ex_fwd_sel_rs1, 0);
        set_id(1, 9, 1, 9, 1, 11, 1, 0);
        #1;
        chk("post_flush_stall", hazard_stall, 0);
        tick();
        chk("post_flush_sel_rs1", ex_fwd_sel_rs1, 0);
        chk("post_flush_sel_rs2", ex_fwd_sel_rs2, 0);
        chk("post_flush_inflight", inflight_cnt, 1);

        idle();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
